// File: rtl/dma_controller.sv
// Bus-master DMA engine that requests the bus with BR/BG, copies LENGTH device words into memory and pulses dma_end.
// Optional build macro DMA_BURST_RELEASE_EN: BR is released for one cycle between BURST-word blocks.
module dma_controller #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned LENGTH    = 12,
  parameter int unsigned BURST     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  input  logic [WORD_SIZE-1:0] cmd_addr,
  output logic                 busy,
  output logic                 BR,
  input  logic                 BG,
  output logic [3:0]           dev_idx,
  input  logic [WORD_SIZE-1:0] dev_data,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_data,
  input  logic                 mem_ack,
  output logic [3:0]           dma_state,
  output logic                 dma_end
);

`ifdef DMA_BURST_RELEASE_EN
  typedef enum logic [2:0] {ST_IDLE, ST_REQUEST, ST_WRITE, ST_DONE, ST_RELEASE} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_REQUEST, ST_WRITE, ST_DONE} state_e;
`endif

  localparam logic [3:0] LAST_IDX = 4'(LENGTH - 1);

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] base_q, base_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_data_q, mem_data_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 br_q, br_d;
  logic                 mem_write_q, mem_write_d;
  logic                 dma_end_q, dma_end_d;
  logic                 issue;

`ifdef DMA_BURST_RELEASE_EN
  logic block_end;
  assign block_end = ((32'(cnt_q) + 32'd1) % BURST) == 32'd0;
`endif

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    br_d        = br_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    dma_end_d   = 1'b0;
    issue       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          base_d  = cmd_addr;
          cnt_d   = '0;
          br_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        if (BG) begin
          issue   = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // A write already on the bus is always completed; new writes need BG.
        if (mem_write_q) begin
          if (mem_ack) begin
            mem_write_d = 1'b0;
            if (cnt_q == LAST_IDX) begin
              cnt_d     = '0;
              br_d      = 1'b0;
              busy_d    = 1'b0;
              dma_end_d = 1'b1;
              state_d   = ST_DONE;
            end
`ifdef DMA_BURST_RELEASE_EN
            else if (block_end) begin
              cnt_d   = cnt_q + 4'd1;
              br_d    = 1'b0;
              state_d = ST_RELEASE;
            end
`endif
            else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end else if (BG) begin
          issue = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
`ifdef DMA_BURST_RELEASE_EN
      ST_RELEASE: begin
        br_d    = 1'b1;
        state_d = ST_REQUEST;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // dev_idx already points at the word being issued, so dev_data is valid here.
    if (issue) begin
      mem_write_d = 1'b1;
      mem_addr_d  = base_q + WORD_SIZE'(cnt_q);
      mem_data_d  = dev_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      br_q        <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      dma_end_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      br_q        <= br_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      dma_end_q   <= dma_end_d;
    end
  end

  assign busy      = busy_q;
  assign BR        = br_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign dma_end   = dma_end_q;
  assign dev_idx   = cnt_q;
  assign dma_state = cnt_q;

endmodule

// File: tb/tb_dma_controller.sv
// Randomized bench for dma_controller: a bus-protocol reference model tracks each transfer word by word.
module tb_dma_controller;
  localparam int unsigned WS  = 16;
  localparam int unsigned LEN = 12;
  localparam int unsigned BST = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [WS-1:0] cmd_addr = '0;
  logic          BG = 1'b0;
  logic          mem_ack = 1'b0;
  logic          busy, BR, mem_write, dma_end;
  logic [3:0]    dev_idx, dma_state;
  logic [WS-1:0] dev_data, mem_addr, mem_data;
  logic [WS-1:0] dev_buf [16];

  assign dev_data = dev_buf[dev_idx];

  dma_controller #(.WORD_SIZE(WS), .LENGTH(LEN), .BURST(BST)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .busy(busy), .BR(BR), .BG(BG), .dev_idx(dev_idx), .dev_data(dev_data),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ack(mem_ack), .dma_state(dma_state), .dma_end(dma_end)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_br"}, BR, 0);
    check_eq({pfx, "_mw"}, mem_write, 0);
    check_eq({pfx, "_maddr"}, mem_addr, 0);
    check_eq({pfx, "_mdata"}, mem_data, 0);
    check_eq({pfx, "_devidx"}, dev_idx, 0);
    check_eq({pfx, "_state"}, dma_state, 0);
    check_eq({pfx, "_end"}, dma_end, 0);
  endtask

  // Protocol phases seen from the bus: idle, waiting for a grant to issue a word,
  // word outstanding, one-cycle block release, completion pulse.
  typedef enum int {M_IDLE, M_REQ, M_WAIT, M_REL, M_DONE} mph_e;
  mph_e          ph = M_IDLE;
  logic [WS-1:0] base = '0;
  logic [WS-1:0] exp_a;
  int            idx = 0;
  int            age = 0;
  int            ack_dly = 1;
  logic          s_cmd = 1'b0, s_bg = 1'b0, s_ack = 1'b0;
  logic [WS-1:0] s_addr = '0;
  int unsigned   bg_pct = 100;
  int unsigned   bg_block = 0;
  int            drop_word = -1;
  int unsigned   ack_max = 1;
  bit            spur_ack = 1'b0;
  int            xfers = 0;
  int            n_writes = 0;

  // s_* hold the inputs the DUT sampled on the posedge that just passed.
  always @(negedge clk) begin
    if (!reset_n) begin
      ph = M_IDLE; mem_ack = 1'b0; BG = 1'b0;
      s_cmd = 1'b0; s_bg = 1'b0; s_ack = 1'b0;
    end else begin
      exp_a = base + 16'(idx);
      case (ph)
        M_IDLE: begin
          if (s_cmd) begin
            base = s_addr; idx = 0;
            check_eq("start_br", BR, 1);
            check_eq("start_busy", busy, 1);
            check_eq("start_mw", mem_write, 0);
            check_eq("start_state", dma_state, 0);
            ph = M_REQ;
          end else begin
            check_eq("idle_busy", busy, 0);
            check_eq("idle_br", BR, 0);
            check_eq("idle_mw", mem_write, 0);
            check_eq("idle_end", dma_end, 0);
          end
        end
        M_REQ: begin
          check_eq("req_br", BR, 1);
          check_eq("req_busy", busy, 1);
          check_eq("req_state", dma_state, idx);
          check_eq("req_devidx", dev_idx, idx);
          check_eq("req_end", dma_end, 0);
          if (s_bg) begin
            check_eq("issue_mw", mem_write, 1);
            check_eq("issue_addr", mem_addr, exp_a);
            check_eq("issue_data", mem_data, dev_buf[idx]);
            ph = M_WAIT; age = 0;
            ack_dly = 1 + int'($urandom_range(ack_max - 1));
            if (idx == drop_word) bg_block = 4;
          end else begin
            check_eq("nogrant_mw", mem_write, 0);
          end
        end
        M_WAIT: begin
          if (s_ack) begin
            idx++; n_writes++;
            check_eq("ack_mw", mem_write, 0);
            if (idx == int'(LEN)) begin
              check_eq("done_end", dma_end, 1);
              check_eq("done_br", BR, 0);
              check_eq("done_busy", busy, 0);
              check_eq("done_state", dma_state, 0);
              ph = M_DONE; xfers++;
            end
`ifdef DMA_BURST_RELEASE_EN
            else if (idx % int'(BST) == 0) begin
              check_eq("rel_br", BR, 0);
              check_eq("rel_busy", busy, 1);
              check_eq("rel_state", dma_state, idx);
              check_eq("rel_end", dma_end, 0);
              ph = M_REL;
            end
`endif
            else begin
              check_eq("next_br", BR, 1);
              check_eq("next_state", dma_state, idx);
              check_eq("next_end", dma_end, 0);
              ph = M_REQ;
            end
          end else begin
            check_eq("hold_mw", mem_write, 1);
            check_eq("hold_addr", mem_addr, exp_a);
            check_eq("hold_data", mem_data, dev_buf[idx]);
            check_eq("hold_br", BR, 1);
            check_eq("hold_state", dma_state, idx);
            age++;
          end
        end
        M_REL: begin
          check_eq("rereq_br", BR, 1);
          check_eq("rereq_mw", mem_write, 0);
          check_eq("rereq_state", dma_state, idx);
          ph = M_REQ;
        end
        M_DONE: begin
          check_eq("post_end", dma_end, 0);
          check_eq("post_busy", busy, 0);
          check_eq("post_br", BR, 0);
          ph = M_IDLE;
        end
        default: ph = M_IDLE;
      endcase

      if (BR && bg_block > 0) bg_block--;
      BG = (bg_block == 0) && ($urandom_range(99) < bg_pct);
      if (ph == M_WAIT && mem_write && age >= ack_dly) mem_ack = 1'b1;
      else if (ph == M_IDLE && spur_ack) mem_ack = 1'($urandom_range(1));
      else mem_ack = 1'b0;
      s_cmd = cmd_valid; s_addr = cmd_addr; s_bg = BG; s_ack = mem_ack;
    end
  end

  task automatic load_buf();
    for (int i = 0; i < 16; i++) dev_buf[i] = 16'($urandom);
  endtask

  task automatic do_xfer(input logic [WS-1:0] b, input int unsigned pct, input int unsigned hold,
                         input int dw, input bit collide);
    int start_x, start_w;
    load_buf();
    bg_pct = pct; bg_block = hold; drop_word = dw;
    start_x = xfers; start_w = n_writes;
    @(posedge clk); #2 cmd_valid = 1'b1; cmd_addr = b;
    @(posedge clk); #2 cmd_valid = 1'b0;
    for (int c = 0; c < 800 && xfers == start_x; c++) begin
      @(posedge clk); #2;
      if (collide && (dma_end || (busy && c == 10))) begin
        cmd_valid = 1'b1; cmd_addr = 16'h0200;
      end else begin
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    check_eq("xfer_count", xfers - start_x, 1);
    check_eq("xfer_words", n_writes - start_w, LEN);
    repeat (3) @(posedge clk);
  endtask

  task automatic reset_mid();
    bit hit = 1'b0;
    load_buf();
    bg_pct = 100; bg_block = 0; drop_word = -1; ack_max = 2;
    @(posedge clk); #2 cmd_valid = 1'b1; cmd_addr = 16'h0100;
    @(posedge clk); #2 cmd_valid = 1'b0;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(posedge clk); #2;
      if (dma_state == 4'd7 && mem_write) hit = 1'b1;
    end
    check_eq("rst_reach", hit, 1);
    reset_n = 1'b0;
    #1 check_all_zero("rst_mid");
    @(posedge clk); #2 reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [WS-1:0] b;
    load_buf();
    #12 check_all_zero("rst");
    @(posedge clk); #2 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    ack_max = 1; spur_ack = 1'b0;
    do_xfer(16'h0100, 100, 0, -1, 1'b0);   // basic
    do_xfer(16'h0100, 100, 6, -1, 1'b0);   // grant delay
    do_xfer(16'h0100, 100, 0, 5, 1'b0);    // BG drop on word 5
    do_xfer(16'h0100, 100, 0, -1, 1'b1);   // command collisions
    reset_mid();
    do_xfer(16'h0300, 100, 0, -1, 1'b0);   // restart after reset

    spur_ack = 1'b1;
    for (int t = 0; t < 16; t++) begin
      if (t % 4 == 3) b = 16'hFFF8 + 16'($urandom_range(7));
      else b = 16'($urandom);
      ack_max = 1 + $urandom_range(3);
      do_xfer(b, 30 + $urandom_range(70), $urandom_range(4), int'($urandom_range(11)), (t % 2) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
